b02_linea_tx: RTL and testbench
===============================

Name: b02_linea_tx

Overview:
Serial BCD line generator driving the LINEA input of the b02 recognizer. It accepts 4-bit digits over a valid/ready port and buffers them in a small FIFO. Each digit is emitted on LINEA as one framed bit stream: a start bit, then 4 data bits MSB first, then idle gap bits. It serves as a stimulus source and the transmit end of the b02 serial line.

Parameters:
DEPTH, 4, FIFO depth in digits (power of 2, >=2)
BIT_CYCLES, 1, clock cycles per line bit (>=1)
GAP_BITS, 1, idle bit times after each frame (>=0)

Ports:
clock  input  1  single clock; all state on rising edge
RESET_G  input  1  asynchronous, active-high reset
din_valid  input  1  digit offered
din  input  4  digit value; legal range 0..9
din_ready  output  1  FIFO not full (combinational)
bad_digit  output  1  one-cycle pulse: digit >9 offered and rejected
LINEA  output  1  serial line, registered
busy  output  1  FSM not in IDLE
frame_done  output  1  one-cycle pulse at end of a frame's data bits
fifo_count  output  $clog2(DEPTH+1)  digits currently buffered

Behaviour:
- Reset (async, RESET_G=1): LINEA=0, busy=0, frame_done=0, bad_digit=0, fifo_count=0, FSM=IDLE, FIFO emptied, bit/cycle counters cleared. Reset mid-frame aborts the frame immediately. No partial frame resumes.
- Push: a digit is accepted when din_valid & din_ready & din<=9. It is written at that clock edge, and fifo_count increments unless a pop happens in the same cycle.
- Bad digit: din_valid & din_ready & din>9 writes nothing and sets bad_digit=1 for the next cycle. No pulse when din_ready=0.
- din_ready = (fifo_count != DEPTH). It does not consider a same-cycle pop. A push while full is ignored with no error.
- Same-cycle push and pop: fifo_count is unchanged and order is preserved.
- FSM states: IDLE, START, DATA, GAP.
  - IDLE: LINEA=0. If fifo_count>0, pop the head into the shift register and go to START.
  - START: LINEA=1 for BIT_CYCLES cycles, then go to DATA.
  - DATA: LINEA=d3,d2,d1,d0, each held BIT_CYCLES cycles.
  - After d0: frame_done=1 for the first cycle of the following state. If GAP_BITS>0, go to GAP with LINEA=0 for GAP_BITS*BIT_CYCLES cycles.
  - GAP_BITS=0: DATA exits directly as if leaving GAP.
  - Leaving GAP: if FIFO is non-empty, pop and go to START with no extra idle cycle; otherwise go to IDLE.
- Latency: a push at edge t (FIFO empty, IDLE) gives pop at edge t+1 and start bit on LINEA from cycle t+2.
- Frame period: (5+GAP_BITS)*BIT_CYCLES cycles back-to-back.
- LINEA is driven only from a flop; it is glitch-free.
- busy=1 in START, DATA and GAP.
- Counters: the bit-time counter is $clog2(BIT_CYCLES) bits wide, min 1, and wraps to 0 at each bit boundary. The data index is 2 bits. The gap counter is sized for GAP_BITS.

Decomposition:
- Package b02_pkg:
  - state enum (IDLE, START, DATA, GAP)
  - DIGIT_W=4, BCD_MAX=4'd9
  - LINE_IDLE=1'b0, LINE_START=1'b1
- Sub-module b02_digit_fifo: synchronous FIFO, DEPTH x DIGIT_W, with push/pop/count/full/empty and async active-high reset on RESET_G.
- The top level holds the FSM, shift register and counters.

Test Plan:
(All tests use BIT_CYCLES=1, GAP_BITS=1, DEPTH=4 unless stated.)
1. Assert RESET_G -> LINEA=0, busy=0, din_ready=1, fifo_count=0, bad_digit=0, frame_done=0; hold for 10 cycles with no activity.
2. Push 5 at cycle 0 -> LINEA cycles 2..6 = 1,0,1,0,1; cycle 7 LINEA=0 with frame_done=1; busy=1 in cycles 2..7 and 0 at cycle 8.
3. Push 9 then 3 on consecutive cycles -> LINEA from cycle 2 = 1,1,0,0,1,0,1,0,0,1,1,0 with no extra idle; frame_done pulses at cycles 7 and 13.
4. Hold din_valid with digits 1..7 every cycle -> din_ready low exactly while fifo_count==4; all accepted digits appear on LINEA in order with none lost or duplicated; repeat with BIT_CYCLES=3 and GAP_BITS=0.
5. Offer din=4'hA, then 4'hF -> bad_digit pulses one cycle after each; fifo_count stays 0; LINEA stays 0.
6. Push 6 and assert RESET_G during data bit d1 with 2 more digits queued -> LINEA=0 and fifo_count=0 asynchronously; after release, push 2 -> clean frame 1,0,0,1,0.

Source files
------------

// File: rtl/b02_linea_tx_pkg.sv
// ---------------------------------------------------------------------------
// b02_pkg
// Shared definitions for the b02 LINEA transmitter slice: the transmit FSM
// state type, the digit width, the largest legal BCD value and the two line
// levels used when the line is resting or carrying a start bit.
// ---------------------------------------------------------------------------
package b02_pkg;

   // Transmit FSM states: resting line, start bit, four data bits, idle gap
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      GAP   = 2'd3
   } state_t;

   localparam int                 DIGIT_W = 4;
   localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

   localparam logic LINE_IDLE  = 1'b0;
   localparam logic LINE_START = 1'b1;

endpackage

// File: rtl/b02_linea_tx_fifo.sv
// ---------------------------------------------------------------------------
// b02_digit_fifo
// Synchronous FIFO of DEPTH digits, DIGIT_W bits each. DEPTH must be a power
// of two so the read/write pointers wrap on their own.
// Ports:
//   clock    - rising-edge clock
//   RESET_G  - asynchronous active-high reset, empties the FIFO
//   i_push   - write i_data at this edge (ignored when full)
//   i_pop    - drop the head entry at this edge (ignored when empty)
//   i_data   - digit to write
//   o_head   - current head entry (valid when not empty)
//   o_count  - number of digits stored
//   o_full   - count equals DEPTH
//   o_empty  - count is zero
// ---------------------------------------------------------------------------
module b02_digit_fifo
   import b02_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clock,
   input  logic                       RESET_G,
   input  logic                       i_push,
   input  logic                       i_pop,
   input  logic [DIGIT_W-1:0]         i_data,
   output logic [DIGIT_W-1:0]         o_head,
   output logic [$clog2(DEPTH+1)-1:0] o_count,
   output logic                       o_full,
   output logic                       o_empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [DIGIT_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]   r_wrPtr;
   logic [PTR_W-1:0]   r_rdPtr;
   logic [CNT_W-1:0]   r_count;
   logic               w_push;
   logic               w_pop;

   assign o_full  = (r_count == CNT_W'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_head  = r_mem[r_rdPtr];

   // Guard the raw requests so a push into a full FIFO or a pop from an empty
   // one can never corrupt the pointers, whatever the caller does
   assign w_push = i_push && !o_full;
   assign w_pop  = i_pop  && !o_empty;

   // Storage carries no reset: an entry is only ever read after it was written
   always_ff @(posedge clock) begin
      if (w_push) begin
         r_mem[r_wrPtr] <= i_data;
      end
   end

   // Pointers and occupancy; a simultaneous push and pop leaves the count alone
   always_ff @(posedge clock or posedge RESET_G) begin
      if (RESET_G) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wrPtr <= r_wrPtr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + PTR_W'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + CNT_W'(1);
         end else if (w_pop && !w_push) begin
            r_count <= r_count - CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/b02_linea_tx.sv
// ---------------------------------------------------------------------------
// b02_linea_tx
// Serial BCD line generator for the LINEA input of the b02 recognizer.
// Digits arrive over a valid/ready port, are buffered in a small FIFO, and
// each one goes out as a start bit, four data bits MSB first, then GAP_BITS
// idle bit times. Every bit lasts BIT_CYCLES clocks.
// Ports:
//   clock       - rising-edge clock
//   RESET_G     - asynchronous active-high reset, aborts any frame
//   din_valid   - a digit is offered
//   din         - offered digit, legal range 0..9
//   din_ready   - FIFO not full (combinational)
//   bad_digit   - one-cycle pulse after an out-of-range digit was refused
//   LINEA       - registered serial line
//   busy        - transmitter is framing a digit
//   frame_done  - one-cycle pulse once a frame's data bits are finished
//   fifo_count  - digits waiting in the FIFO
// ---------------------------------------------------------------------------
module b02_linea_tx
   import b02_pkg::*;
#(
   parameter int DEPTH      = 4,
   parameter int BIT_CYCLES = 1,
   parameter int GAP_BITS   = 1
) (
   input  logic                       clock,
   input  logic                       RESET_G,
   input  logic                       din_valid,
   input  logic [DIGIT_W-1:0]         din,
   output logic                       din_ready,
   output logic                       bad_digit,
   output logic                       LINEA,
   output logic                       busy,
   output logic                       frame_done,
   output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int BIT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam int GAP_W = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BIT_CYCLES - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

   state_t             r_state;
   state_t             w_stateNxt;
   logic [BIT_W-1:0]   r_bitCnt;
   logic [BIT_W-1:0]   w_bitNxt;
   logic [1:0]         r_dataIdx;
   logic [1:0]         w_idxNxt;
   logic [GAP_W-1:0]   r_gapCnt;
   logic [GAP_W-1:0]   w_gapNxt;
   logic [DIGIT_W-1:0] r_shift;
   logic [DIGIT_W-1:0] w_shiftNxt;
   logic [DIGIT_W-1:0] w_head;
   logic [CNT_W-1:0]   w_count;
   logic               w_full;
   logic               w_empty;
   logic               w_push;
   logic               w_pop;
   logic               w_bad;
   logic               w_bitEnd;
   logic               w_frameEnd;
   logic               w_lineNxt;
   logic               r_line;
   logic               r_busy;
   logic               r_fdPre;
   logic               r_frameDone;
   logic               r_bad;

   // Only in-range digits are written; a refused digit is flagged instead
   assign din_ready = !w_full;
   assign w_push    = din_valid && din_ready && (din <= BCD_MAX);
   assign w_bad     = din_valid && din_ready && (din >  BCD_MAX);
   assign w_bitEnd  = (r_bitCnt == BIT_LAST);

   b02_digit_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock   (clock),
      .RESET_G (RESET_G),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (din),
      .o_head  (w_head),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // Next-state logic. Leaving a frame (end of gap, or end of data when there
   // is no gap) pops straight into the next start bit so back-to-back frames
   // have no dead cycle between them.
   always_comb begin
      w_stateNxt = r_state;
      w_bitNxt   = r_bitCnt;
      w_idxNxt   = r_dataIdx;
      w_gapNxt   = r_gapCnt;
      w_shiftNxt = r_shift;
      w_pop      = 1'b0;
      w_frameEnd = 1'b0;
      w_lineNxt  = LINE_IDLE;
      unique case (r_state)
         IDLE: begin
            if (!w_empty) begin
               w_pop      = 1'b1;
               w_shiftNxt = w_head;
               w_bitNxt   = '0;
               w_stateNxt = START;
            end
         end
         START: begin
            w_lineNxt = LINE_START;
            if (w_bitEnd) begin
               w_bitNxt   = '0;
               w_idxNxt   = '0;
               w_stateNxt = DATA;
            end else begin
               w_bitNxt = r_bitCnt + BIT_W'(1);
            end
         end
         DATA: begin
            w_lineNxt = r_shift[DIGIT_W-1];
            if (w_bitEnd) begin
               w_bitNxt = '0;
               if (r_dataIdx == 2'd3) begin
                  w_frameEnd = 1'b1;
                  if (GAP_BITS > 0) begin
                     w_gapNxt   = '0;
                     w_stateNxt = GAP;
                  end else if (!w_empty) begin
                     w_pop      = 1'b1;
                     w_shiftNxt = w_head;
                     w_stateNxt = START;
                  end else begin
                     w_stateNxt = IDLE;
                  end
               end else begin
                  w_idxNxt   = r_dataIdx + 2'd1;
                  w_shiftNxt = {r_shift[DIGIT_W-2:0], 1'b0};
               end
            end else begin
               w_bitNxt = r_bitCnt + BIT_W'(1);
            end
         end
         GAP: begin
            if (w_bitEnd) begin
               w_bitNxt = '0;
               if (r_gapCnt == GAP_LAST) begin
                  if (!w_empty) begin
                     w_pop      = 1'b1;
                     w_shiftNxt = w_head;
                     w_stateNxt = START;
                  end else begin
                     w_stateNxt = IDLE;
                  end
               end else begin
                  w_gapNxt = r_gapCnt + GAP_W'(1);
               end
            end else begin
               w_bitNxt = r_bitCnt + BIT_W'(1);
            end
         end
         default: begin
            w_stateNxt = IDLE;
         end
      endcase
   end

   // FSM state, shift register and bit/data/gap counters
   always_ff @(posedge clock or posedge RESET_G) begin
      if (RESET_G) begin
         r_state   <= IDLE;
         r_bitCnt  <= '0;
         r_dataIdx <= '0;
         r_gapCnt  <= '0;
         r_shift   <= '0;
      end else begin
         r_state   <= w_stateNxt;
         r_bitCnt  <= w_bitNxt;
         r_dataIdx <= w_idxNxt;
         r_gapCnt  <= w_gapNxt;
         r_shift   <= w_shiftNxt;
      end
   end

   // Output flops. The line level is decoded from the current state and
   // registered, so LINEA and busy trail the state by one cycle. frame_done is
   // delayed by a second stage so it lands on the first line cycle after d0.
   always_ff @(posedge clock or posedge RESET_G) begin
      if (RESET_G) begin
         r_line      <= LINE_IDLE;
         r_busy      <= 1'b0;
         r_fdPre     <= 1'b0;
         r_frameDone <= 1'b0;
         r_bad       <= 1'b0;
      end else begin
         r_line      <= w_lineNxt;
         r_busy      <= (r_state != IDLE);
         r_fdPre     <= w_frameEnd;
         r_frameDone <= r_fdPre;
         r_bad       <= w_bad;
      end
   end

   assign LINEA      = r_line;
   assign busy       = r_busy;
   assign frame_done = r_frameDone;
   assign bad_digit  = r_bad;
   assign fifo_count = w_count;

endmodule

// File: tb/tb_b02_linea_tx.sv
// ---------------------------------------------------------------------------
// tb_b02_linea_tx
// Drives two transmitters with the same directed stimulus: one with
// BIT_CYCLES=1/GAP_BITS=1 and one with BIT_CYCLES=3/GAP_BITS=0. Each has a
// cycle-timeline model that schedules the expected waveform of a whole frame
// whenever a digit leaves its model FIFO, and is compared every cycle.
// ---------------------------------------------------------------------------
module tb_b02_linea_tx;

   localparam int MAXC  = 4000;
   localparam int DEPTH = 4;

   logic       clock = 1'b0;
   logic       RESET_G;
   logic       din_valid;
   logic [3:0] din;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int maxCount = 0;

   bit hLine [MAXC];
   bit hBusy [MAXC];
   bit hFd   [MAXC];

   int          e, e2, f, s, k, guard, nDec, fdCnt, c;
   bit          rdy;
   logic [31:0] got;
   logic [31:0] want;

   always #5 clock = ~clock;

   always @(posedge clock) cyc++;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
      end
   endtask

   // Two instances with their own timeline model and per-cycle compare
   for (genvar g = 0; g < 2; g++) begin : gi
      localparam int BC  = (g == 0) ? 1 : 3;
      localparam int GB  = (g == 0) ? 1 : 0;
      localparam int PER = (5 + GB) * BC;

      logic       w_ready, w_bad, w_line, w_busy, w_fd;
      logic [2:0] w_count;

      b02_linea_tx #(
         .DEPTH      (DEPTH),
         .BIT_CYCLES (BC),
         .GAP_BITS   (GB)
      ) dut (
         .clock      (clock),
         .RESET_G    (RESET_G),
         .din_valid  (din_valid),
         .din        (din),
         .din_ready  (w_ready),
         .bad_digit  (w_bad),
         .LINEA      (w_line),
         .busy       (w_busy),
         .frame_done (w_fd),
         .fifo_count (w_count)
      );

      bit         expLine [MAXC];
      bit         expBusy [MAXC];
      bit         expFd   [MAXC];
      logic [3:0] mq [$];
      logic [3:0] mDigit;
      int         mCount   = 0;
      int         freeEdge = 0;
      int         mEdge    = 0;
      int         mC, mBi;
      bit         mBad, mPush, mReady;
      bit         eLine, eBusy, eFd, eBad, eRdy;
      int         eCnt;

      // Model: a digit leaves the FIFO at the first edge where the line is
      // free and something was buffered; its whole frame is then written
      // into the expected timeline starting on the following cycle.
      always @(posedge clock) begin
         mEdge++;
         if (RESET_G) begin
            mq.delete();
            mCount   = 0;
            mBad     = 0;
            freeEdge = 0;
            for (int i = mEdge; i < MAXC; i++) begin
               expLine[i] = 0;
               expBusy[i] = 0;
               expFd[i]   = 0;
            end
         end else begin
            mReady = (mCount != DEPTH);
            mBad   = din_valid && mReady && (din > 4'd9);
            mPush  = din_valid && mReady && (din <= 4'd9);
            if (mEdge >= freeEdge && mCount > 0) begin
               mDigit = mq.pop_front();
               for (int j = 0; j < PER; j++) begin
                  mC  = mEdge + 1 + j;
                  mBi = j / BC;
                  if (mC < MAXC) begin
                     expBusy[mC] = 1;
                     if (mBi == 0)      expLine[mC] = 1;
                     else if (mBi <= 4) expLine[mC] = mDigit[4 - mBi];
                     else               expLine[mC] = 0;
                  end
               end
               if (mEdge + 1 + 5 * BC < MAXC) expFd[mEdge + 1 + 5 * BC] = 1;
               freeEdge = mEdge + PER;
            end
            if (mPush) mq.push_back(din);
            mCount = mq.size();
         end
      end

      // Compare every cycle, away from the rising edge
      always @(negedge clock) begin
         if (mEdge < MAXC) begin
            if (RESET_G) begin
               eLine = 0; eBusy = 0; eFd = 0; eBad = 0; eRdy = 1; eCnt = 0;
            end else begin
               eLine = expLine[mEdge];
               eBusy = expBusy[mEdge];
               eFd   = expFd[mEdge];
               eBad  = mBad;
               eCnt  = mCount;
               eRdy  = (mCount != DEPTH);
            end
            checkOutput($sformatf("dut%0d_LINEA_c%0d", g, mEdge), w_line, eLine);
            checkOutput($sformatf("dut%0d_busy_c%0d", g, mEdge), w_busy, eBusy);
            checkOutput($sformatf("dut%0d_frame_done_c%0d", g, mEdge), w_fd, eFd);
            checkOutput($sformatf("dut%0d_bad_digit_c%0d", g, mEdge), w_bad, eBad);
            checkOutput($sformatf("dut%0d_fifo_count_c%0d", g, mEdge), w_count, eCnt);
            checkOutput($sformatf("dut%0d_din_ready_c%0d", g, mEdge), w_ready, eRdy);
         end
      end
   end

   // Waveform history of the first instance for the literal checks
   always @(negedge clock) begin
      if (cyc < MAXC) begin
         hLine[cyc] = gi[0].w_line;
         hBusy[cyc] = gi[0].w_busy;
         hFd[cyc]   = gi[0].w_fd;
      end
      if (int'(gi[0].w_count) > maxCount) maxCount = int'(gi[0].w_count);
   end

   function automatic logic [31:0] packHist(input int from, input int n);
      logic [31:0] r = '0;
      for (int i = 0; i < n; i++) r = {r[30:0], hLine[from + i]};
      return r;
   endfunction

   // Call at a negedge: present the inputs for the next rising edge and
   // return the index of the edge that sampled them
   task automatic applyStimulus(input bit v, input logic [3:0] d, output int edgeIdx);
      din_valid = v;
      din       = d;
      @(negedge clock);
      edgeIdx   = cyc;
      din_valid = 1'b0;
   endtask

   task automatic idleCycles(input int n);
      din_valid = 1'b0;
      repeat (n) @(negedge clock);
   endtask

   initial begin
      RESET_G   = 1'b1;
      din_valid = 1'b0;
      din       = 4'd0;

      // Reset state
      repeat (3) @(negedge clock);
      checkOutput("rst_LINEA", gi[0].w_line, 0);
      checkOutput("rst_busy", gi[0].w_busy, 0);
      checkOutput("rst_din_ready", gi[0].w_ready, 1);
      checkOutput("rst_fifo_count", gi[0].w_count, 0);
      checkOutput("rst_bad_digit", gi[0].w_bad, 0);
      checkOutput("rst_frame_done", gi[0].w_fd, 0);
      repeat (7) @(negedge clock);
      @(posedge clock);
      #1 RESET_G = 1'b0;
      @(negedge clock);
      idleCycles(10);
      checkOutput("idle_LINEA", gi[0].w_line, 0);

      // Single digit 5
      applyStimulus(1'b1, 4'd5, e);
      idleCycles(12);
      want = 32'b101010;
      checkOutput("t2_line", packHist(e + 2, 6), want);
      checkOutput("t2_fd_c7", hFd[e + 7], 1);
      checkOutput("t2_fd_c6", hFd[e + 6], 0);
      checkOutput("t2_busy_c1", hBusy[e + 1], 0);
      checkOutput("t2_busy_c2", hBusy[e + 2], 1);
      checkOutput("t2_busy_c7", hBusy[e + 7], 1);
      checkOutput("t2_busy_c8", hBusy[e + 8], 0);
      got = '0;
      for (int i = 0; i < 6; i++) got = {got[30:0], gi[0].expLine[e + 2 + i]};
      checkOutput("model0_line5", got, want);
      got = '0;
      for (int i = 0; i < 15; i++) got = {got[30:0], gi[1].expLine[e + 2 + i]};
      want = 32'b111000111000111;
      checkOutput("model1_line5", got, want);
      checkOutput("model1_fd5", gi[1].expFd[e + 17], 1);
      idleCycles(10);

      // Back-to-back 9 then 3
      applyStimulus(1'b1, 4'd9, e);
      applyStimulus(1'b1, 4'd3, e2);
      idleCycles(15);
      want = 32'b110010100110;
      checkOutput("t3_line", packHist(e + 2, 12), want);
      checkOutput("t3_fd_c7", hFd[e + 7], 1);
      checkOutput("t3_fd_c8", hFd[e + 8], 0);
      checkOutput("t3_fd_c13", hFd[e + 13], 1);
      idleCycles(40);

      // Streaming 1..7 with valid held high
      maxCount = 0;
      s = cyc;
      k = 1;
      guard = 0;
      while (k <= 7 && guard < 100) begin
         din_valid = 1'b1;
         din       = 4'(k);
         rdy       = gi[0].w_ready;
         @(negedge clock);
         if (rdy) k++;
         guard++;
      end
      din_valid = 1'b0;
      checkOutput("t4_all_offered", k, 8);
      idleCycles(130);
      checkOutput("t4_max_count", maxCount, 4);
      fdCnt = 0;
      for (int i = s; i < cyc; i++) fdCnt += int'(hFd[i]);
      checkOutput("t4_frame_done_pulses", fdCnt, 7);
      nDec = 0;
      c = s;
      while (c + 5 < cyc) begin
         if (hLine[c]) begin
            nDec++;
            checkOutput($sformatf("t4_digit%0d", nDec), packHist(c + 1, 4), nDec);
            c += 6;
         end else begin
            c++;
         end
      end
      checkOutput("t4_frames", nDec, 7);

      // Out-of-range digits
      applyStimulus(1'b1, 4'hA, e);
      checkOutput("t5_bad_A", gi[0].w_bad, 1);
      applyStimulus(1'b1, 4'hF, e);
      checkOutput("t5_bad_F", gi[0].w_bad, 1);
      idleCycles(1);
      checkOutput("t5_bad_clear", gi[0].w_bad, 0);
      checkOutput("t5_fifo_count", gi[0].w_count, 0);
      checkOutput("t5_LINEA", gi[0].w_line, 0);
      idleCycles(5);

      // Reset in the middle of data bit d1 with two digits queued
      applyStimulus(1'b1, 4'd6, e);
      applyStimulus(1'b1, 4'd7, e2);
      applyStimulus(1'b1, 4'd8, e2);
      guard = 0;
      while (cyc < e + 4 && guard < 10) begin
         @(negedge clock);
         guard++;
      end
      @(posedge clock);
      #1;
      checkOutput("t6_pre_LINEA_d1", gi[0].w_line, 1);
      checkOutput("t6_pre_fifo_count", gi[0].w_count, 2);
      RESET_G = 1'b1;
      #1;
      checkOutput("t6_async_LINEA", gi[0].w_line, 0);
      checkOutput("t6_async_fifo_count", gi[0].w_count, 0);
      checkOutput("t6_async_busy", gi[0].w_busy, 0);
      repeat (2) @(posedge clock);
      #1 RESET_G = 1'b0;
      @(negedge clock);
      applyStimulus(1'b1, 4'd2, f);
      idleCycles(10);
      want = 32'b10010;
      checkOutput("t6_line", packHist(f + 2, 5), want);
      checkOutput("t6_line_before", hLine[f + 1], 0);
      checkOutput("t6_line_gap", hLine[f + 7], 0);
      checkOutput("t6_fd", hFd[f + 7], 1);
      idleCycles(20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
